// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard.
// Provides the register-file geometry, the countdown width, the forwarding
// select encoding and a helper that maps a zero issue latency to one cycle.
package fwd_scoreboard_pkg;

    localparam int NREG        = 32;
    localparam int REG_AW      = 5;
    localparam int NUM_SRC     = 2;
    localparam int MAX_LAT     = 8;
    localparam int CNT_W       = $clog2(MAX_LAT + 1);
    localparam int STALL_CNT_W = 16;
    localparam int REG_ZERO    = 0;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // A latency of 0 is meaningless for an in-flight result; treat it as 1.
    function automatic logic [CNT_W-1:0] eff_lat(input logic [CNT_W-1:0] lat);
        return (lat == '0) ? CNT_W'(1) : lat;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Issue / bypass / status bundle for the forwarding scoreboard.
// master: the pipeline side that presents instructions and bypass state.
// slave : the scoreboard, which returns forwarding selects, stall and the
//         stall-cycle counter.
interface fwd_scoreboard_if;
    import fwd_scoreboard_pkg::*;

    logic                         issue_valid;
    logic                         issue_we;
    logic [REG_AW-1:0]            issue_rd;
    logic [CNT_W-1:0]             issue_lat;
    logic [NUM_SRC-1:0]           src_en;
    logic [NUM_SRC*REG_AW-1:0]    src_rs;
    logic                         ex_mem_we;
    logic [REG_AW-1:0]            ex_mem_rd;
    logic                         mem_wb_we;
    logic [REG_AW-1:0]            mem_wb_rd;
    logic                         flush;
    logic                         stall_cnt_clr;
    fwd_sel_e                     fwd_sel [NUM_SRC];
    logic                         stall;
    logic [STALL_CNT_W-1:0]       stall_cnt;

    modport master (
        output issue_valid, issue_we, issue_rd, issue_lat, src_en, src_rs,
               ex_mem_we, ex_mem_rd, mem_wb_we, mem_wb_rd, flush, stall_cnt_clr,
        input  fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_lat, src_en, src_rs,
               ex_mem_we, ex_mem_rd, mem_wb_we, mem_wb_rd, flush, stall_cnt_clr,
        output fwd_sel, stall, stall_cnt
    );

endinterface

// File: rtl/fwd_sb_entry.sv
// One scoreboard entry: a busy flag plus a countdown to result availability.
// Ports: clk, rst (async, active high), flush (clears), load/load_val (new
// in-flight write), retire (result written back), busy/cnt (entry state).
// Priority: flush > load > retire > decrement.
module fwd_sb_entry
    import fwd_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             retire,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (flush) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            busy <= 1'b1;
            cnt  <= load_val;
        end else if (retire) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (cnt != '0) begin
            // busy stays set at cnt==0: the value is forwardable but the
            // register has not been written back yet.
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding and hazard unit with a per-register scoreboard.
// Ports: clk, rst (async, active high), sb (slave side of the issue/bypass
// bundle). Outputs per-source forwarding selects, a combinational stall
// (source not yet forwardable, or an out-of-order write-after-write) and a
// saturating stall-cycle counter.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fwd_scoreboard_if.slave sb
);

    logic [NREG-1:0]        busy;
    logic [CNT_W-1:0]       cnt [NREG];
    logic [NREG-1:1]        load;
    logic [NREG-1:1]        retire;
    logic [CNT_W-1:0]       lat_eff;
    logic [NUM_SRC-1:0]     haz;
    logic                   waw;
    logic                   stall_raw;
    logic                   issue_fire;
    logic [STALL_CNT_W-1:0] stall_cnt_reg;

    // Register zero is never tracked.
    assign busy[0] = 1'b0;
    assign cnt[0]  = '0;

    assign lat_eff = eff_lat(sb.issue_lat);

    always_comb begin
        haz = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [REG_AW-1:0] rs;
            rs     = sb.src_rs[i*REG_AW +: REG_AW];
            haz[i] = sb.src_en[i] && (rs != REG_AW'(REG_ZERO)) && busy[rs] && (cnt[rs] != '0);
        end
    end

    // A younger write must not complete before an older one to the same rd.
    assign waw = sb.issue_we && (sb.issue_rd != REG_AW'(REG_ZERO)) &&
                 busy[sb.issue_rd] && (cnt[sb.issue_rd] >= lat_eff);

    assign stall_raw  = sb.issue_valid && ((|haz) || waw);
    assign sb.stall   = !rst && stall_raw;
    assign issue_fire = sb.issue_valid && !stall_raw && !sb.flush;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [REG_AW-1:0] rs;
            rs = sb.src_rs[i*REG_AW +: REG_AW];
            sb.fwd_sel[i] = FWD_NONE;
            if (!rst && sb.src_en[i] && (rs != REG_AW'(REG_ZERO)) && !haz[i]) begin
                if (sb.ex_mem_we && (sb.ex_mem_rd == rs)) begin
                    sb.fwd_sel[i] = FWD_EXMEM;
                end else if (sb.mem_wb_we && (sb.mem_wb_rd == rs)) begin
                    sb.fwd_sel[i] = FWD_MEMWB;
                end
            end
        end
    end

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
            assign load[gi]   = issue_fire && sb.issue_we && (sb.issue_rd == REG_AW'(gi));
            assign retire[gi] = sb.mem_wb_we && (sb.mem_wb_rd == REG_AW'(gi));

            fwd_sb_entry u_entry (
                .clk      (clk),
                .rst      (rst),
                .flush    (sb.flush),
                .load     (load[gi]),
                .load_val (lat_eff),
                .retire   (retire[gi]),
                .busy     (busy[gi]),
                .cnt      (cnt[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (sb.stall_cnt_clr) begin
            stall_cnt_reg <= '0;
        end else if (stall_raw && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
        end
    end

    assign sb.stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus random
// traffic, all compared against a per-register countdown model.
module tb_fwd_scoreboard;
    import fwd_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_scoreboard_if sb_if ();

    fwd_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    int checks = 0;
    int errors = 0;

    int m_busy [NREG];
    int m_cnt  [NREG];
    int m_scnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int lat);
        return (lat == 0) ? 1 : lat;
    endfunction

    function automatic int rs_of(input int i);
        return int'(sb_if.src_rs[i*REG_AW +: REG_AW]);
    endfunction

    function automatic bit m_haz(input int i);
        int rs;
        rs = rs_of(i);
        return sb_if.src_en[i] && rs != 0 && m_busy[rs] != 0 && m_cnt[rs] > 0;
    endfunction

    function automatic bit m_stall();
        int  rd;
        bit  waw;
        bit  any;
        rd  = int'(sb_if.issue_rd);
        waw = sb_if.issue_we && rd != 0 && m_busy[rd] != 0 &&
              m_cnt[rd] >= eff(int'(sb_if.issue_lat));
        any = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) any = any | m_haz(i);
        return sb_if.issue_valid && (any || waw);
    endfunction

    function automatic int m_fwd(input int i);
        int rs;
        rs = rs_of(i);
        if (!sb_if.src_en[i] || rs == 0 || m_haz(i)) return int'(FWD_NONE);
        if (sb_if.ex_mem_we && int'(sb_if.ex_mem_rd) == rs) return int'(FWD_EXMEM);
        if (sb_if.mem_wb_we && int'(sb_if.mem_wb_rd) == rs) return int'(FWD_MEMWB);
        return int'(FWD_NONE);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            m_busy[r] = 0;
            m_cnt[r]  = 0;
        end
        m_scnt = 0;
    endtask

    task automatic idle();
        sb_if.issue_valid   = 1'b0;
        sb_if.issue_we      = 1'b0;
        sb_if.issue_rd      = '0;
        sb_if.issue_lat     = '0;
        sb_if.src_en        = '0;
        sb_if.src_rs        = '0;
        sb_if.ex_mem_we     = 1'b0;
        sb_if.ex_mem_rd     = '0;
        sb_if.mem_wb_we     = 1'b0;
        sb_if.mem_wb_rd     = '0;
        sb_if.flush         = 1'b0;
        sb_if.stall_cnt_clr = 1'b0;
    endtask

    task automatic issue(input bit we, input int rd, input int lat);
        sb_if.issue_valid = 1'b1;
        sb_if.issue_we    = we;
        sb_if.issue_rd    = REG_AW'(rd);
        sb_if.issue_lat   = CNT_W'(lat);
    endtask

    task automatic srcs(input logic [1:0] en, input int rs0, input int rs1);
        sb_if.src_en = en;
        sb_if.src_rs = {REG_AW'(rs1), REG_AW'(rs0)};
    endtask

    // Check outputs against the model, clock once, advance the model.
    task automatic step(input bit chk);
        bit s;
        bit fire;
        int rd;
        #1;
        s = m_stall();
        if (chk) begin
            check("stall", {31'd0, sb_if.stall}, {31'd0, s});
            for (int i = 0; i < NUM_SRC; i++)
                check($sformatf("fwd_sel%0d", i), 32'(sb_if.fwd_sel[i]), 32'(m_fwd(i)));
            check("stall_cnt", 32'(sb_if.stall_cnt), 32'(m_scnt));
        end
        fire = sb_if.issue_valid && !s && !sb_if.flush;
        if (chk && sb_if.issue_valid)
            $display("t=%0t issue we=%0d rd=%0d lat=%0d fire=%0d stall=%0d flush=%0d",
                     $time, sb_if.issue_we, sb_if.issue_rd, sb_if.issue_lat, fire, s, sb_if.flush);
        @(posedge clk);
        rd = int'(sb_if.issue_rd);
        if (sb_if.flush) begin
            for (int r = 0; r < NREG; r++) begin
                m_busy[r] = 0;
                m_cnt[r]  = 0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (fire && sb_if.issue_we && rd == r) begin
                    m_busy[r] = 1;
                    m_cnt[r]  = eff(int'(sb_if.issue_lat));
                end else if (sb_if.mem_wb_we && int'(sb_if.mem_wb_rd) == r) begin
                    m_busy[r] = 0;
                    m_cnt[r]  = 0;
                end else if (m_cnt[r] > 0) begin
                    m_cnt[r] = m_cnt[r] - 1;
                end
            end
        end
        if (sb_if.stall_cnt_clr) m_scnt = 0;
        else if (s && m_scnt < 65535) m_scnt = m_scnt + 1;
        #1;
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) step(1'b1);
    endtask

    initial begin
        idle();
        model_clear();
        rst = 1'b1;
        sb_if.ex_mem_we = 1'b1;
        sb_if.ex_mem_rd = REG_AW'(5);
        srcs(2'b01, 5, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {31'd0, sb_if.stall}, 32'd0);
        check("rst_fwd0", 32'(sb_if.fwd_sel[0]), 32'(FWD_NONE));
        check("rst_scnt", 32'(sb_if.stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // Short-latency producer, then consumer via EX/MEM and MEM/WB.
        issue(1'b1, 5, 1); step(1'b1);
        idle(); issue(1'b0, 0, 0); srcs(2'b01, 5, 0);
        sb_if.ex_mem_we = 1'b1; sb_if.ex_mem_rd = REG_AW'(5);
        hold(2);
        sb_if.ex_mem_we = 1'b0;
        sb_if.mem_wb_we = 1'b1; sb_if.mem_wb_rd = REG_AW'(5);
        hold(2);

        // Long-latency producer: source stall, then EX/MEM forward.
        idle(); sb_if.stall_cnt_clr = 1'b1; step(1'b1);
        idle(); issue(1'b1, 7, 4); step(1'b1);
        idle(); issue(1'b0, 0, 0); srcs(2'b01, 7, 0);
        sb_if.ex_mem_we = 1'b1; sb_if.ex_mem_rd = REG_AW'(7);
        hold(6);

        // Write-after-write: reissue of r9 with a shorter latency waits.
        idle(); issue(1'b1, 9, 6); step(1'b1);
        issue(1'b1, 9, 2); hold(8);

        // Register zero is neither hazarded nor forwarded nor tracked.
        idle(); issue(1'b1, 0, 3); srcs(2'b11, 0, 0);
        sb_if.ex_mem_we = 1'b1; sb_if.ex_mem_rd = '0;
        #1;
        check("r0_fwd0", 32'(sb_if.fwd_sel[0]), 32'(FWD_NONE));
        hold(2);

        // Flush drops in-flight state and the same-cycle issue.
        idle(); issue(1'b1, 3, 5); step(1'b1);
        issue(1'b1, 4, 3); sb_if.flush = 1'b1; step(1'b1);
        idle(); issue(1'b0, 0, 0); srcs(2'b11, 3, 4); hold(2);

        // Random traffic over a small register window to provoke collisions.
        for (int k = 0; k < 1500; k++) begin
            sb_if.issue_valid   = ($urandom_range(0, 3) != 0);
            sb_if.issue_we      = $urandom_range(0, 1);
            sb_if.issue_rd      = REG_AW'($urandom_range(0, 7));
            sb_if.issue_lat     = CNT_W'($urandom_range(0, MAX_LAT));
            srcs(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7));
            sb_if.ex_mem_we     = $urandom_range(0, 1);
            sb_if.ex_mem_rd     = REG_AW'($urandom_range(0, 7));
            sb_if.mem_wb_we     = $urandom_range(0, 1);
            sb_if.mem_wb_rd     = REG_AW'($urandom_range(0, 7));
            sb_if.flush         = ($urandom_range(0, 31) == 0);
            sb_if.stall_cnt_clr = ($urandom_range(0, 63) == 0);
            step(1'b1);
        end

        // Saturate the stall counter: a self-dependent issue stalls 8 of 9 cycles.
        idle(); sb_if.flush = 1'b1; sb_if.stall_cnt_clr = 1'b1; step(1'b1);
        idle(); issue(1'b1, 1, MAX_LAT); srcs(2'b01, 1, 0);
        for (int k = 0; k < 74000; k++) step(1'b0);
        #1;
        check("scnt_model", 32'(sb_if.stall_cnt), 32'(m_scnt));
        check("scnt_sat", 32'(sb_if.stall_cnt), 32'hFFFF);
        sb_if.stall_cnt_clr = 1'b1; step(1'b1);
        sb_if.stall_cnt_clr = 1'b0;
        check("scnt_clr", 32'(sb_if.stall_cnt), 32'd0);

        // Asynchronous reset while stalled.
        idle(); sb_if.flush = 1'b1; step(1'b1);
        idle(); issue(1'b1, 7, MAX_LAT); step(1'b1);
        idle(); issue(1'b0, 0, 0); srcs(2'b11, 7, 8);
        sb_if.ex_mem_we = 1'b1; sb_if.ex_mem_rd = REG_AW'(8);
        step(1'b1);
        #1;
        check("pre_rst_stall", {31'd0, sb_if.stall}, 32'd1);
        check("pre_rst_fwd1", 32'(sb_if.fwd_sel[1]), 32'(FWD_EXMEM));
        #2;
        rst = 1'b1;
        #1;
        check("midrst_stall", {31'd0, sb_if.stall}, 32'd0);
        check("midrst_fwd1", 32'(sb_if.fwd_sel[1]), 32'(FWD_NONE));
        check("midrst_scnt", 32'(sb_if.stall_cnt), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        hold(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
